// File: rtl/imem_pkg.sv
// imem_pkg
// Shared constants and response record for the instruction fetch path.
// The program counter and the fetch side both import this package so the
// address and instruction widths stay in step across the interface.
//   ADDR_W     : word-address width (PC output width)
//   DATA_W     : instruction word width
//   imem_rsp_t : one response entry {addr, err, data}
package imem_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              err;
        logic [DATA_W-1:0] data;
    } imem_rsp_t;

endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// rsp_fifo
// Synchronous FIFO of imem_rsp_t entries, used as the response buffer of
// the instruction-memory responder.
// Ports:
//   clk        : clock, all state changes on posedge
//   reset_n    : asynchronous active-low reset (empties the FIFO)
//   push       : write push_data at the tail this cycle
//   push_data  : entry to write
//   pop        : remove the head this cycle (ignored while empty)
//   count      : number of valid entries, 0..DEPTH
//   head       : entry at the head; all zeros while empty
module rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  imem_rsp_t                      push_data,
    input  logic                           pop,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output imem_rsp_t                      head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    imem_rsp_t        slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (cnt != '0);
    // A push into a full FIFO is only accepted when the head leaves in the
    // same cycle; upstream flow control keeps this from ever being needed.
    assign do_push = push && ((cnt != FULL) || do_pop);

    // Entry storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign count = cnt;
    assign head  = (cnt != '0) ? slots[rd_ptr] : '0;

endmodule

// File: rtl/imem_responder.sv
// imem_responder
// Memory side of the instruction fetch interface. Accepts word-address
// fetch requests, reads the instruction store in one registered stage and
// returns {addr, err, data} through a small response FIFO that absorbs
// consumer backpressure while sustaining one fetch per cycle.
// Ports:
//   clk       : clock
//   reset_n   : asynchronous active-low reset (store contents survive)
//   req_valid : fetch request present
//   req_ready : request accepted this cycle (registered state only)
//   req_addr  : word address to fetch
//   rsp_valid : response present at FIFO head
//   rsp_ready : consumer takes the head this cycle
//   rsp_data  : instruction word, 0 for out-of-range addresses
//   rsp_addr  : address the response belongs to
//   rsp_err   : requested address was >= DEPTH
//   ld_en     : write one word into the store
//   ld_addr   : load address, dropped if >= DEPTH
//   ld_data   : load data
// Address and data widths come from imem_pkg so they match the PC.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int FIFO_D = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [SUM_W-1:0] OCC_LIMIT = SUM_W'(FIFO_D - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic             accept;
    logic             req_in_range;
    logic             ld_in_range;
    logic             s1_valid;
    imem_rsp_t        s1_rsp;
    logic [CNT_W-1:0] fifo_count;
    imem_rsp_t        fifo_head;

    assign req_in_range = {1'b0, req_addr} < DEPTH_L;
    assign ld_in_range  = {1'b0, ld_addr} < DEPTH_L;

    // Accept only while the FIFO can hold every response already in
    // flight plus this one, so a stalled consumer never causes overflow.
    assign req_ready = reset_n &&
                       ((SUM_W'(fifo_count) + SUM_W'(s1_valid)) <= OCC_LIMIT);
    assign accept    = req_valid && req_ready;

    // Store is not reset. A load and a fetch of the same word in one cycle
    // returns the old word because the read below samples before the write.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_rsp   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_rsp.addr <= req_addr;
                s1_rsp.err  <= !req_in_range;
                s1_rsp.data <= req_in_range ? mem[req_addr] : '0;
            end
        end
    end

    rsp_fifo #(
        .DEPTH (FIFO_D)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s1_valid),
        .push_data (s1_rsp),
        .pop       (rsp_ready),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign rsp_valid = (fifo_count != '0);
    assign rsp_data  = fifo_head.data;
    assign rsp_addr  = fifo_head.addr;
    assign rsp_err   = fifo_head.err;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
    import imem_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;

    int tests = 0;
    int fails = 0;

    imem_responder #(
        .DEPTH  (48),
        .FIFO_D (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Single fetch from an idle responder: accept, response visible after
    // the following edge, then consume it.
    task automatic fetch_one(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] exp_d, input logic exp_e);
        check({tag, "_ready"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        check({tag, "_valid_s1"}, 64'(rsp_valid), 64'(0));
        tick();
        check({tag, "_valid"}, 64'(rsp_valid), 64'(1));
        check({tag, "_data"}, 64'(rsp_data), 64'(exp_d));
        check({tag, "_addr"}, 64'(rsp_addr), 64'(a));
        check({tag, "_err"}, 64'(rsp_err), 64'(exp_e));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_empty"}, 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        logic exp_rdy [6];
        int   acc;

        // Reset state, applied asynchronously before any clock edge
        #3 reset_n = 1'b0;
        #1;
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_data", 64'(rsp_data), 64'(0));
        check("rst_addr", 64'(rsp_addr), 64'(0));
        check("rst_err", 64'(rsp_err), 64'(0));

        // Store loads work while reset is held; contents are not reset
        for (int i = 0; i < 4; i++) begin
            load(ADDR_W'(i), DATA_W'(32'hA0 + i));
        end
        load(6'd5, 32'h11);
        load(6'd18, 32'h18);
        load(6'd47, 32'h47);
        check("rst_hold_ready", 64'(req_ready), 64'(0));

        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'(1));

        // 1: first fetch
        fetch_one("t1", 6'd0, 32'hA0, 1'b0);

        // 2: streaming with consumer always ready
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                req_valid = 1'b1;
                req_addr  = ADDR_W'(k);
                check("t2_ready", 64'(req_ready), 64'(1));
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (k >= 1 && k <= 4) begin
                check("t2_valid", 64'(rsp_valid), 64'(1));
                check("t2_data", 64'(rsp_data), 64'(32'hA0 + k - 1));
                check("t2_addr", 64'(rsp_addr), 64'(k - 1));
            end else if (k == 5) begin
                check("t2_drained", 64'(rsp_valid), 64'(0));
            end
        end
        rsp_ready = 1'b0;

        // 3: backpressure, exactly three accepted before req_ready drops
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1;
            req_addr  = ADDR_W'(acc);
            check("t3_ready", 64'(req_ready), 64'(exp_rdy[k]));
            if (exp_rdy[k]) acc++;
            tick();
            if (k >= 1) begin
                check("t3_head_valid", 64'(rsp_valid), 64'(1));
                check("t3_head_data", 64'(rsp_data), 64'(32'hA0));
            end
        end
        req_addr = ADDR_W'(acc);
        check("t3_full_ready", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        tick();
        check("t3_d1_data", 64'(rsp_data), 64'(32'hA1));
        check("t3_d1_addr", 64'(rsp_addr), 64'(1));
        check("t3_resume_ready", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        check("t3_d2_data", 64'(rsp_data), 64'(32'hA2));
        tick();
        check("t3_d3_data", 64'(rsp_data), 64'(32'hA3));
        check("t3_d3_addr", 64'(rsp_addr), 64'(3));
        tick();
        check("t3_drained", 64'(rsp_valid), 64'(0));
        rsp_ready = 1'b0;

        // 4: load/fetch collision on address 5 returns the old word
        ld_en     = 1'b1;
        ld_addr   = 6'd5;
        ld_data   = 32'h22;
        req_valid = 1'b1;
        req_addr  = 6'd5;
        tick();
        ld_en     = 1'b0;
        req_valid = 1'b0;
        tick();
        check("t4_old_valid", 64'(rsp_valid), 64'(1));
        check("t4_old_data", 64'(rsp_data), 64'(32'h11));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        fetch_one("t4_new", 6'd5, 32'h22, 1'b0);

        // 5: range boundary with DEPTH=48
        fetch_one("t5_47", 6'd47, 32'h47, 1'b0);
        fetch_one("t5_48", 6'd48, 32'h0, 1'b1);
        fetch_one("t5_50", 6'd50, 32'h0, 1'b1);
        load(6'd50, 32'hDEAD_BEEF);
        fetch_one("t5_50_after_ld", 6'd50, 32'h0, 1'b1);
        fetch_one("t5_18_alias", 6'd18, 32'h18, 1'b0);
        fetch_one("t5_2_alias", 6'd2, 32'hA2, 1'b0);

        // 6: reset with two buffered responses and one in stage 1
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_addr  = ADDR_W'(k);
            tick();
        end
        check("t6_pre_valid", 64'(rsp_valid), 64'(1));
        check("t6_pre_ready", 64'(req_ready), 64'(0));
        #3 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(rsp_valid), 64'(0));
        check("t6_rst_ready", 64'(req_ready), 64'(0));
        check("t6_rst_data", 64'(rsp_data), 64'(0));
        tick();
        check("t6_low_ready", 64'(req_ready), 64'(0));
        check("t6_low_valid", 64'(rsp_valid), 64'(0));
        req_valid = 1'b0;
        reset_n   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_no_stale", 64'(rsp_valid), 64'(0));
        end
        fetch_one("t6_mem0", 6'd0, 32'hA0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
